// File: rtl/branch_pkg.sv
// Shared encodings for the branch/jump controller: modes, C2 condition codes, FSM states.
package branch_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned C2_W   = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_BR  = 2'd0,
        MODE_JR  = 2'd1,
        MODE_JAL = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    // Codes 8..15 are reserved and deliberately left out of the enum.
    typedef enum logic [C2_W-1:0] {
        C2_BRZR   = 4'd0,
        C2_BRNZ   = 4'd1,
        C2_BRPL   = 4'd2,
        C2_BRMI   = 4'd3,
        C2_ALWAYS = 4'd4,
        C2_NEVER  = 4'd5,
        C2_BRGT   = 4'd6,
        C2_BRLE   = 4'd7
    } c2_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        EVAL    = 3'd2,
        CALC    = 3'd3,
        COMMIT  = 3'd4
    } state_e;

endpackage

// File: rtl/branch_ctrl_con_eval.sv
// Combinational condition evaluator: maps (C2, Ra) to taken/reserved, signed view of Ra.
module con_eval
    import branch_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [C2_W-1:0]   c2,
    input  logic [DATA_W-1:0] ra,
    output logic              taken_c,
    output logic              reserved_c
);

    logic zero;
    logic neg;

    assign zero = (ra == '0);
    assign neg  = ra[DATA_W-1];

    always_comb begin
        taken_c    = 1'b0;
        reserved_c = 1'b0;
        case (c2_e'(c2))
            C2_BRZR:   taken_c = zero;
            C2_BRNZ:   taken_c = !zero;
            C2_BRPL:   taken_c = !neg;
            C2_BRMI:   taken_c = neg;
            C2_ALWAYS: taken_c = 1'b1;
            C2_NEVER:  taken_c = 1'b0;
            C2_BRGT:   taken_c = !neg && !zero;
            C2_BRLE:   taken_c = neg || zero;
            default:   reserved_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Self-timed conditional branch / JR / JAL controller with integrated CON FF.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned OFFSET_W = 19,
    parameter int unsigned C2_LSB   = 19
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] ir,
    input  logic [DATA_W-1:0] ra_value,
    input  logic [DATA_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              con_out,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_next,
    output logic              link_we,
    output logic [DATA_W-1:0] link_data,
    output logic              illegal
);

    localparam int unsigned EXT_W = DATA_W - OFFSET_W;

    state_e                state_q, state_d;
    mode_e                 mode_q;
    logic [C2_W-1:0]       c2_q;
    logic [OFFSET_W-1:0]   off_q;
    logic [DATA_W-1:0]     ra_q;
    logic [DATA_W-1:0]     pc_q;

    logic                  cap_en;
    logic                  busy_d, done_d, con_d, pc_load_d, link_we_d, illegal_d;
    logic [DATA_W-1:0]     pc_next_d, link_data_d;

    logic                  taken_c, reserved_c, illegal_c;
    logic [DATA_W-1:0]     offset_ext_c, target_c;

    con_eval #(.DATA_W(DATA_W)) u_con_eval (
        .c2         (c2_q),
        .ra         (ra_q),
        .taken_c    (taken_c),
        .reserved_c (reserved_c)
    );

    // Target: PC-relative for BR, register-indirect for JR/JAL; silent wrap.
    assign offset_ext_c = {{EXT_W{off_q[OFFSET_W-1]}}, off_q};
    assign target_c     = (mode_q == MODE_BR) ? (pc_q + offset_ext_c) : ra_q;
    assign illegal_c    = (mode_q == MODE_RSV) || ((mode_q == MODE_BR) && reserved_c);

    always_comb begin
        state_d     = state_q;
        cap_en      = 1'b0;
        con_d       = con_out;
        done_d      = 1'b0;
        pc_load_d   = 1'b0;
        link_we_d   = 1'b0;
        illegal_d   = 1'b0;
        pc_next_d   = pc_next;
        link_data_d = link_data;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CAPTURE;
                    cap_en  = 1'b1;
                end
            end
            CAPTURE: state_d = EVAL;
            EVAL: begin
                state_d = CALC;
                case (mode_q)
                    MODE_BR:           con_d = taken_c;
                    MODE_JR, MODE_JAL: con_d = 1'b1;
                    default:           con_d = 1'b0;
                endcase
            end
            // Commit strobes are registered here so they are live during COMMIT.
            CALC: begin
                state_d     = COMMIT;
                done_d      = 1'b1;
                illegal_d   = illegal_c;
                pc_load_d   = con_out && !illegal_c;
                pc_next_d   = target_c;
                link_we_d   = (mode_q == MODE_JAL);
                link_data_d = pc_q;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            mode_q    <= MODE_BR;
            c2_q      <= '0;
            off_q     <= '0;
            ra_q      <= '0;
            pc_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            con_out   <= 1'b0;
            pc_load   <= 1'b0;
            pc_next   <= '0;
            link_we   <= 1'b0;
            link_data <= '0;
            illegal   <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy      <= busy_d;
            done      <= done_d;
            con_out   <= con_d;
            pc_load   <= pc_load_d;
            pc_next   <= pc_next_d;
            link_we   <= link_we_d;
            link_data <= link_data_d;
            illegal   <= illegal_d;
            if (cap_en) begin
                mode_q <= mode_e'(mode);
                c2_q   <= ir[C2_LSB +: C2_W];
                off_q  <= ir[OFFSET_W-1:0];
                ra_q   <= ra_value;
                pc_q   <= pc;
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: expected commit results queued at issue, checked on done.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] ir, ra_value, pc;
    logic        busy, done, con_out, pc_load, link_we, illegal;
    logic [31:0] pc_next, link_data;

    typedef struct {
        string       name;
        logic        con;
        logic        pc_load;
        logic [31:0] pc_next;
        logic        link_we;
        logic [31:0] link_data;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    branch_ctrl #(.DATA_W(32), .OFFSET_W(19), .C2_LSB(19)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .mode      (mode),
        .ir        (ir),
        .ra_value  (ra_value),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .con_out   (con_out),
        .pc_load   (pc_load),
        .pc_next   (pc_next),
        .link_we   (link_we),
        .link_data (link_data),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input string n, input logic c, input logic pl, input logic [31:0] pn,
                                input logic lw, input logic [31:0] ld, input logic il);
        exp_t e;
        e.name = n; e.con = c; e.pc_load = pl; e.pc_next = pn;
        e.link_we = lw; e.link_data = ld; e.illegal = il;
        return e;
    endfunction

    // Commit monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 with empty scoreboard");
            end else begin
                mon_e = sb.pop_front();
                if (con_out !== mon_e.con) begin
                    errors++;
                    $display("FAIL %s con_out: got %b want %b", mon_e.name, con_out, mon_e.con);
                end
                checks++;
                if (pc_load !== mon_e.pc_load) begin
                    errors++;
                    $display("FAIL %s pc_load: got %b want %b", mon_e.name, pc_load, mon_e.pc_load);
                end
                checks++;
                if (link_we !== mon_e.link_we) begin
                    errors++;
                    $display("FAIL %s link_we: got %b want %b", mon_e.name, link_we, mon_e.link_we);
                end
                checks++;
                if (illegal !== mon_e.illegal) begin
                    errors++;
                    $display("FAIL %s illegal: got %b want %b", mon_e.name, illegal, mon_e.illegal);
                end
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_in_commit: got %b want 1", mon_e.name, busy);
                end
                if (mon_e.pc_load) begin
                    checks++;
                    if (pc_next !== mon_e.pc_next) begin
                        errors++;
                        $display("FAIL %s pc_next: got %h want %h", mon_e.name, pc_next, mon_e.pc_next);
                    end
                end
                if (mon_e.link_we) begin
                    checks++;
                    if (link_data !== mon_e.link_data) begin
                        errors++;
                        $display("FAIL %s link_data: got %h want %h", mon_e.name, link_data, mon_e.link_data);
                    end
                end
            end
        end else if (pc_load || link_we || illegal) begin
            checks++;
            errors++;
            $display("FAIL stray_strobe: pc_load=%b link_we=%b illegal=%b without done", pc_load, link_we, illegal);
        end
    end

    task automatic issue(input logic [1:0] m, input logic [31:0] i, input logic [31:0] r,
                         input logic [31:0] p, input exp_t e, input bit expect_it);
        @(posedge clk); #1;
        mode = m; ir = i; ra_value = r; pc = p; start = 1'b1;
        if (expect_it) sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout: busy still %b after 12 cycles, want 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b0; mode = 2'd0; ir = '0; ra_value = '0; pc = '0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, con_out, pc_load, link_we, illegal} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000", {busy, done, con_out, pc_load, link_we, illegal});
        end
        checks++;
        if (pc_next !== 32'h0 || link_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got pc_next=%h link_data=%h want 0/0", pc_next, link_data);
        end
    endtask

    task automatic test_conditions();
        issue(2'd0, 32'h9B000019, 32'h0, 32'h5, mk("brzr_taken", 1, 1, 32'h1E, 0, 0, 0), 1);
        wait_idle("brzr_taken");
        issue(2'd0, 32'h9B080019, 32'h0, 32'h5, mk("brnz_not", 0, 0, 0, 0, 0, 0), 1);
        wait_idle("brnz_not");
        issue(2'd0, 32'h9B180019, 32'h80000000, 32'h5, mk("brmi_taken", 1, 1, 32'h1E, 0, 0, 0), 1);
        wait_idle("brmi_taken");
        issue(2'd0, 32'h9B100019, 32'h80000000, 32'h5, mk("brpl_not", 0, 0, 0, 0, 0, 0), 1);
        wait_idle("brpl_not");
        issue(2'd0, 32'h9B07FFFD, 32'h0, 32'h2, mk("offset_wrap", 1, 1, 32'hFFFFFFFF, 0, 0, 0), 1);
        wait_idle("offset_wrap");
        issue(2'd0, 32'h9B300019, 32'h5, 32'h10, mk("brgt_taken", 1, 1, 32'h29, 0, 0, 0), 1);
        wait_idle("brgt_taken");
        issue(2'd0, 32'h9B300019, 32'hFFFFFFFF, 32'h10, mk("brgt_neg", 0, 0, 0, 0, 0, 0), 1);
        wait_idle("brgt_neg");
        issue(2'd0, 32'h9B380019, 32'h5, 32'h10, mk("brle_not", 0, 0, 0, 0, 0, 0), 1);
        wait_idle("brle_not");
        issue(2'd0, 32'h9B380019, 32'h0, 32'h10, mk("brle_zero", 1, 1, 32'h29, 0, 0, 0), 1);
        wait_idle("brle_zero");
        issue(2'd0, 32'h9B280019, 32'h0, 32'h10, mk("never", 0, 0, 0, 0, 0, 0), 1);
        wait_idle("never");
        issue(2'd0, 32'h9B480019, 32'h0, 32'h10, mk("c2_reserved", 0, 0, 0, 0, 0, 1), 1);
        wait_idle("c2_reserved");
    endtask

    task automatic test_jumps();
        issue(2'd1, 32'h0, 32'h200, 32'h44, mk("jr", 1, 1, 32'h200, 0, 0, 0), 1);
        wait_idle("jr");
        issue(2'd2, 32'h0, 32'h100, 32'h40, mk("jal", 1, 1, 32'h100, 1, 32'h40, 0), 1);
        wait_idle("jal");
        issue(2'd3, 32'h9B200019, 32'h100, 32'h40, mk("mode_rsv", 0, 0, 0, 0, 0, 1), 1);
        wait_idle("mode_rsv");
    endtask

    task automatic test_latency();
        int lat = 0;
        @(posedge clk); #1;
        mode = 2'd0; ir = 32'h9B200019; ra_value = 32'h0; pc = 32'h100; start = 1'b1;
        sb.push_back(mk("latency_op", 1, 1, 32'h119, 0, 0, 0));
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done) begin lat = k; break; end
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL latency: done seen %0d half-cycles-after-accept index, want 4", lat);
        end
        wait_idle("latency");
    endtask

    task automatic test_ignore_busy();
        int base = done_cnt;
        issue(2'd0, 32'h9B000019, 32'h0, 32'h5, mk("ignore_main", 1, 1, 32'h1E, 0, 0, 0), 1);
        @(posedge clk); #1;
        mode = 2'd2; ir = 32'h0; ra_value = 32'h300; pc = 32'h77; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("ignore_busy");
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt - base != 1) begin
            errors++;
            $display("FAIL ignore_busy_done_count: got %0d want 1", done_cnt - base);
        end
    endtask

    task automatic test_clr_mid();
        int base = done_cnt;
        issue(2'd2, 32'h0, 32'h100, 32'h40, mk("aborted", 1, 1, 32'h100, 1, 32'h40, 0), 0);
        @(posedge clk);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, con_out, pc_load, link_we, illegal} !== 6'b0) begin
            errors++;
            $display("FAIL clr_mid_flags: got %b want 000000", {busy, done, con_out, pc_load, link_we, illegal});
        end
        checks++;
        if (pc_next !== 32'h0 || link_data !== 32'h0) begin
            errors++;
            $display("FAIL clr_mid_data: got pc_next=%h link_data=%h want 0/0", pc_next, link_data);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt != base) begin
            errors++;
            $display("FAIL clr_mid_no_done: got %0d dones want 0", done_cnt - base);
        end
        @(posedge clk); #1;
        clr = 1'b1; start = 1'b1; mode = 2'd1; ra_value = 32'h500;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_priority: got busy=%b want 0", busy);
        end
        issue(2'd0, 32'h9B000019, 32'h0, 32'h5, mk("after_clr", 1, 1, 32'h1E, 0, 0, 0), 1);
        wait_idle("after_clr");
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        issue(2'd0, 32'h9B000019, 32'h0, 32'h5, mk("b2b_first", 1, 1, 32'h1E, 0, 0, 0), 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_first_done: got no done in 8 cycles want done");
        end
        issue(2'd2, 32'h0, 32'h1234, 32'h88, mk("b2b_second", 1, 1, 32'h1234, 1, 32'h88, 0), 1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b want 1", busy);
        end
        wait_idle("b2b_second");
    endtask

    initial begin
        test_reset();
        test_conditions();
        test_jumps();
        test_latency();
        test_ignore_busy();
        test_clr_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
